// File: rtl/vpu_arbiter.sv
// Round-robin arbiter and sequencer sharing one vector processor
// between several requesters, with a hang timeout.
module vpu_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [64*NUM_REQ-1:0]   req_vec_a,
  input  logic [64*NUM_REQ-1:0]   req_vec_b,
  input  logic [16*NUM_REQ-1:0]   req_scalar,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [63:0]             rsp_result,
  output logic                    rsp_error,
  output logic                    arb_busy,
  output logic                    vp_start,
  output logic [3:0]              vp_operation,
  output logic [63:0]             vp_vec_a,
  output logic [63:0]             vp_vec_b,
  output logic [15:0]             vp_scalar,
  input  logic                    vp_busy,
  input  logic                    vp_done,
  input  logic                    vp_result_valid,
  input  logic [63:0]             vp_result
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   grant;
  logic            gnt_vld;
  logic            accept;
  logic            tmo;
  logic [CW-1:0]   cnt;

  // Scan downward so the requester closest to rr_ptr is written last.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant   = PW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end

  assign accept = |req_ready;
  assign tmo    = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = ISSUE;
      ISSUE: if (vp_start) state_nx = WAIT;
      WAIT:  if (vp_done || tmo) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    arb_busy  = (state != IDLE);
    if (!rst && state == IDLE && gnt_vld)
      req_ready[grant] = 1'b1;
    if (state == RESP)
      rsp_valid[owner] = 1'b1;
  end

  // Busy is sampled the cycle before the pulse so vp_start is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      vp_start     <= 1'b0;
      vp_operation <= '0;
      vp_vec_a     <= '0;
      vp_vec_b     <= '0;
      vp_scalar    <= '0;
      rr_ptr       <= '0;
      owner        <= '0;
      cnt          <= '0;
      rsp_result   <= '0;
      rsp_error    <= 1'b0;
    end else begin
      vp_start <= !vp_busy &&
                  (accept || (state == ISSUE && !vp_start));
      if (vp_start)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 1'b1;
      if (accept) begin
        vp_operation <= req_op[4*grant +: 4];
        vp_vec_a     <= req_vec_a[64*grant +: 64];
        vp_vec_b     <= req_vec_b[64*grant +: 64];
        vp_scalar    <= req_scalar[16*grant +: 16];
        owner        <= grant;
        rr_ptr       <= (grant == PW'(NUM_REQ - 1)) ?
                        '0 : grant + 1'b1;
      end
      if (state == WAIT) begin
        if (vp_done) begin
          rsp_result <= vp_result;
          rsp_error  <= !vp_result_valid;
        end else if (tmo) begin
          rsp_result <= '0;
          rsp_error  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vpu_arbiter.sv
// Self-checking bench for vpu_arbiter: directed scenarios plus a
// randomized run against a round-robin reference model.
module tb_vpu_arbiter;

  localparam int NR = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [4*NR-1:0] req_op;
  logic [64*NR-1:0] req_vec_a;
  logic [64*NR-1:0] req_vec_b;
  logic [16*NR-1:0] req_scalar;
  logic [NR-1:0]   rsp_valid;
  logic [63:0]     rsp_result;
  logic            rsp_error;
  logic            arb_busy;
  logic            vp_start;
  logic [3:0]      vp_operation;
  logic [63:0]     vp_vec_a;
  logic [63:0]     vp_vec_b;
  logic [15:0]     vp_scalar;
  logic            vp_busy;
  logic            vp_done;
  logic            vp_result_valid;
  logic [63:0]     vp_result;

  int tests = 0;
  int fails = 0;

  logic [3:0]  f_op [NR];
  logic [63:0] f_a  [NR];
  logic [63:0] f_b  [NR];
  logic [15:0] f_s  [NR];
  int          m_ptr;
  logic [63:0] m_res;

  vpu_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_vec_a(req_vec_a),
    .req_vec_b(req_vec_b), .req_scalar(req_scalar),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .arb_busy(arb_busy),
    .vp_start(vp_start), .vp_operation(vp_operation),
    .vp_vec_a(vp_vec_a), .vp_vec_b(vp_vec_b),
    .vp_scalar(vp_scalar), .vp_busy(vp_busy),
    .vp_done(vp_done), .vp_result_valid(vp_result_valid),
    .vp_result(vp_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_grant(int ptr, logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic drive_fields();
    for (int i = 0; i < NR; i++) begin
      req_op[4*i +: 4]      = f_op[i];
      req_vec_a[64*i +: 64] = f_a[i];
      req_vec_b[64*i +: 64] = f_b[i];
      req_scalar[16*i +: 16] = f_s[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NR; i++) begin
      f_op[i] = 4'($urandom);
      f_a[i]  = {$urandom, $urandom};
      f_b[i]  = {$urandom, $urandom};
      f_s[i]  = 16'($urandom);
    end
    drive_fields();
  endtask

  task automatic vpu_respond(int dly, logic rv, logic [63:0] res);
    repeat (dly) tick();
    vp_done = 1'b1;
    vp_result_valid = rv;
    vp_result = res;
    tick();
    vp_done = 1'b0;
    vp_result_valid = 1'b0;
    vp_result = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    m_res = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    tick();
    tests++;
    if ({req_ready, vp_start, rsp_valid, rsp_error, arb_busy} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0",
        {req_ready, vp_start, rsp_valid, rsp_error, arb_busy});
    end
    tests++;
    if ({vp_operation, vp_vec_a, vp_vec_b, vp_scalar, rsp_result} !== '0) begin
      fails++;
      $display("FAIL reset_data got %h %h want 0", vp_vec_a, rsp_result);
    end
    req_valid = '0;
    rst = 1'b0;
    m_ptr = 0;
    m_res = '0;
    tick();
  endtask

  task automatic test_single();
    f_op[0] = 4'h3;
    f_a[0]  = 64'h0001_0002_0003_0004;
    f_b[0]  = 64'h1111_2222_3333_4444;
    f_s[0]  = 16'h00A5;
    drive_fields();
    req_valid = 2'b01;
    #1;
    tests++;
    if (req_ready !== 2'b01) begin
      fails++;
      $display("FAIL single_ready got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    m_ptr = 1;
    tests++;
    if ({vp_start, arb_busy, vp_operation, vp_vec_a, vp_vec_b, vp_scalar} !==
        {2'b11, f_op[0], f_a[0], f_b[0], f_s[0]}) begin
      fails++;
      $display("FAIL single_issue got %b %h %h", vp_start, vp_operation, vp_vec_a);
    end
    tick();
    tests++;
    if (vp_start !== 1'b0 || rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL single_wait got start %b rsp %b want 0 00", vp_start, rsp_valid);
    end
    vpu_respond(3, 1'b1, 64'hAAAA);
    m_res = 64'hAAAA;
    tests++;
    if ({rsp_valid, rsp_error, rsp_result, arb_busy} !== {2'b01, 1'b0, m_res, 1'b1}) begin
      fails++;
      $display("FAIL single_rsp got %b %b %h want 01 0 %h",
        rsp_valid, rsp_error, rsp_result, m_res);
    end
    tick();
    tests++;
    if (rsp_valid !== 2'b00 || arb_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle got %b %b want 00 0", rsp_valid, arb_busy);
    end
  endtask

  task automatic test_fairness();
    int g;
    apply_reset();
    rand_fields();
    req_valid = 2'b11;
    for (int n = 0; n < 6; n++) begin
      g = model_grant(m_ptr, req_valid);
      #1;
      tests++;
      if (req_ready !== 2'(1 << g)) begin
        fails++;
        $display("FAIL fair_grant[%0d] got %b want %b", n, req_ready, 2'(1 << g));
      end
      tick();
      m_ptr = (g + 1) % NR;
      tests++;
      if (dut.rr_ptr !== 1'(m_ptr) || vp_operation !== f_op[g]) begin
        fails++;
        $display("FAIL fair_ptr[%0d] got %0d %h want %0d %h",
          n, dut.rr_ptr, vp_operation, m_ptr, f_op[g]);
      end
      vpu_respond(2, 1'b1, f_a[g] ^ f_b[g]);
      m_res = f_a[g] ^ f_b[g];
      tests++;
      if (rsp_valid !== 2'(1 << g) || rsp_result !== m_res) begin
        fails++;
        $display("FAIL fair_rsp[%0d] got %b %h want %b %h",
          n, rsp_valid, rsp_result, 2'(1 << g), m_res);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    bit seen;
    rand_fields();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    m_ptr = 1;
    tests++;
    if (vp_start !== 1'b1) begin
      fails++;
      $display("FAIL tmo_start got %b want 1", vp_start);
    end
    vp_busy = 1'b1;
    repeat (8) tick();
    tests++;
    if (rsp_valid !== 2'b00) begin
      fails++;
      $display("FAIL tmo_early got %b want 00", rsp_valid);
    end
    tick();
    m_res = '0;
    tests++;
    if ({rsp_valid, rsp_error, rsp_result} !== {2'b01, 1'b1, 64'h0}) begin
      fails++;
      $display("FAIL tmo_rsp got %b %b %h want 01 1 0",
        rsp_valid, rsp_error, rsp_result);
    end
    req_valid = 2'b10;
    tick();
    tick();
    req_valid = '0;
    m_ptr = 0;
    seen = 0;
    repeat (4) begin
      tick();
      if (vp_start) seen = 1;
    end
    tests++;
    if (seen || arb_busy !== 1'b1) begin
      fails++;
      $display("FAIL stale_hold got start %b busy %b want 0 1", seen, arb_busy);
    end
    vp_busy = 1'b0;
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      tick();
      if (vp_start) seen = 1;
    end
    tests++;
    if (!seen || vp_vec_b !== f_b[1]) begin
      fails++;
      $display("FAIL stale_start got %b %h want 1 %h", seen, vp_vec_b, f_b[1]);
    end
    vpu_respond(1, 1'b1, f_a[1]);
    m_res = f_a[1];
    tests++;
    if (rsp_valid !== 2'b10 || rsp_result !== m_res || rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL stale_rsp got %b %h %b", rsp_valid, rsp_result, rsp_error);
    end
    tick();
  endtask

  task automatic test_edges();
    vp_done = 1'b1;
    vp_result_valid = 1'b1;
    vp_result = 64'hDEAD;
    tick();
    vp_done = 1'b0;
    vp_result_valid = 1'b0;
    tick();
    tests++;
    if (rsp_valid !== 2'b00 || arb_busy !== 1'b0 || rsp_result !== m_res) begin
      fails++;
      $display("FAIL idle_done got %b %b %h want 00 0 %h",
        rsp_valid, arb_busy, rsp_result, m_res);
    end
    rand_fields();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    m_ptr = 1;
    vpu_respond(TO, 1'b1, 64'h1234);
    m_res = 64'h1234;
    tests++;
    if ({rsp_valid, rsp_error, rsp_result} !== {2'b01, 1'b0, m_res}) begin
      fails++;
      $display("FAIL coincident got %b %b %h want 01 0 %h",
        rsp_valid, rsp_error, rsp_result, m_res);
    end
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    m_ptr = 0;
    vpu_respond(3, 1'b0, 64'h55);
    m_res = 64'h55;
    tests++;
    if ({rsp_valid, rsp_error, rsp_result} !== {2'b10, 1'b1, m_res}) begin
      fails++;
      $display("FAIL no_result got %b %b %h want 10 1 %h",
        rsp_valid, rsp_error, rsp_result, m_res);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    bit seen;
    rand_fields();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    req_valid = 2'b01;
    tick();
    tests++;
    if ({req_ready, vp_start, rsp_valid, rsp_error, arb_busy, rsp_result,
         vp_operation, vp_vec_a, vp_scalar} !== '0) begin
      fails++;
      $display("FAIL rst_wait got %b %b %b %h want 0",
        req_ready, arb_busy, rsp_valid, vp_vec_a);
    end
    rst = 1'b0;
    req_valid = '0;
    m_ptr = 0;
    m_res = '0;
    vp_done = 1'b1;
    vp_result_valid = 1'b1;
    vp_result = 64'hBAD;
    tick();
    vp_done = 1'b0;
    vp_result_valid = 1'b0;
    seen = 0;
    repeat (3) begin
      tick();
      if (rsp_valid !== 2'b00) seen = 1;
    end
    tests++;
    if (seen || rsp_result !== 64'h0) begin
      fails++;
      $display("FAIL rst_stale got %b %h want 0 0", seen, rsp_result);
    end
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    m_ptr = 0;
    tests++;
    if (vp_start !== 1'b1 || vp_vec_a !== f_a[1]) begin
      fails++;
      $display("FAIL rst_reissue got %b %h want 1 %h", vp_start, vp_vec_a, f_a[1]);
    end
    vpu_respond(2, 1'b1, f_b[1]);
    m_res = f_b[1];
    tests++;
    if (rsp_valid !== 2'b10 || rsp_result !== m_res) begin
      fails++;
      $display("FAIL rst_rsp got %b %h want 10 %h", rsp_valid, rsp_result, m_res);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    int dly;
    logic rv;
    logic [63:0] res;
    for (int n = 0; n < 30; n++) begin
      rand_fields();
      req_valid = 2'($urandom_range(1, 3));
      g = model_grant(m_ptr, req_valid);
      #1;
      tests++;
      if (req_ready !== 2'(1 << g)) begin
        fails++;
        $display("FAIL rnd_grant[%0d] got %b want %b", n, req_ready, 2'(1 << g));
      end
      tick();
      req_valid = '0;
      m_ptr = (g + 1) % NR;
      tests++;
      if ({vp_start, vp_operation, vp_vec_a, vp_vec_b, vp_scalar} !==
          {1'b1, f_op[g], f_a[g], f_b[g], f_s[g]}) begin
        fails++;
        $display("FAIL rnd_issue[%0d] got %b %h %h", n, vp_start, vp_operation, vp_vec_a);
      end
      dly = $urandom_range(1, 5);
      rv  = 1'($urandom);
      res = {$urandom, $urandom};
      vpu_respond(dly, rv, res);
      m_res = res;
      tests++;
      if ({rsp_valid, rsp_error, rsp_result} !== {2'(1 << g), !rv, m_res}) begin
        fails++;
        $display("FAIL rnd_rsp[%0d] got %b %b %h want %b %b %h", n,
          rsp_valid, rsp_error, rsp_result, 2'(1 << g), !rv, m_res);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_vec_a = '0;
    req_vec_b = '0;
    req_scalar = '0;
    vp_busy = 1'b0;
    vp_done = 1'b0;
    vp_result_valid = 1'b0;
    vp_result = '0;
    m_ptr = 0;
    m_res = '0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_edges();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vpu_arbiter.md
# vpu_arbiter

Round-robin arbiter and sequencer that shares the single `vector_processor` between several requesters, such as the shader pipeline and the demo/setup controller. It sits between those clients and the VPU's start/busy/done port. It accepts one request at a time and drives a registered one-cycle `vp_start` with latched operands. It then waits for `vp_done`, returns the result to the owning requester, and aborts with an error if the VPU hangs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 1023: maximum number of WAIT cycles before an operation is aborted. Must be ≥1.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept strobe.
- `req_op`  in  4*NUM_REQ  VPU operation; requester i occupies bits [4i+3:4i].
- `req_vec_a`, `req_vec_b`  in  64*NUM_REQ  operand vectors; requester i occupies bits [64i+63:64i].
- `req_scalar`  in  16*NUM_REQ  scalar operand for each requester.
- `rsp_valid`  out  NUM_REQ  one-cycle one-hot response strobe.
- `rsp_result`  out  64  result, shared by all requesters; qualified by `rsp_valid`.
- `rsp_error`  out  1  set when the response is a timeout or a done-without-result; qualified by `rsp_valid`.
- `arb_busy`  out  1  high in every state except IDLE.
- `vp_start`  out  1  VPU start pulse.
- `vp_operation`  out  4  operation to the VPU.
- `vp_vec_a`, `vp_vec_b`  out  64  operand vectors to the VPU.
- `vp_scalar`  out  16  scalar operand to the VPU.
- `vp_busy`, `vp_done`, `vp_result_valid`  in  1  VPU status inputs.
- `vp_result`  in  64  VPU result.

## Operation
- The FSM has four states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - The grant goes to the first i with `req_valid[i]`=1, scanning from `rr_ptr` upward modulo NUM_REQ.
  - `req_ready[i]` is combinational: high only in IDLE, only for the granted i.
  - On accept (valid && ready), the block:
    - latches op, vec_a, vec_b and scalar into the `vp_*` registers;
    - sets owner = i;
    - sets `rr_ptr` = (i+1) mod NUM_REQ;
    - moves to ISSUE.
  - With no valid request, the FSM stays in IDLE and `rr_ptr` is unchanged.
- **ISSUE**
  - If `vp_busy`=0: assert `vp_start` for exactly one cycle (registered), clear the timeout counter, and go to WAIT.
  - If `vp_busy`=1: hold in ISSUE with `vp_start`=0. This covers a stale VPU operation after reset or timeout.
- **WAIT**
  - The timeout counter increments each cycle.
  - On `vp_done`=1:
    - capture `vp_result` into `rsp_result`;
    - set `rsp_error` = ~`vp_result_valid`;
    - go to RESP.
  - When the counter reaches TIMEOUT_CYCLES without `vp_done`: set `rsp_result`=0 and `rsp_error`=1, then go to RESP.
  - If `vp_done` arrives in the same cycle as the terminal count, done wins and the result is normal.
- **RESP**
  - `rsp_valid[owner]`=1 for one cycle; then return to IDLE.
- `vp_done` and `vp_result_valid` are ignored in IDLE, ISSUE and RESP, so stale completions are discarded.
- Operand registers hold their values until the next accept. Requesters must hold their request fields stable while `req_valid` is high and not yet accepted.
- Requester behaviour and fairness:
  - A requester may drop `req_valid` before it is accepted; no state changes.
  - Each requester has at most one operation outstanding; it must wait for its `rsp_valid` before issuing again.
  - Round-robin guarantees that each continuously-valid requester is served within NUM_REQ grants.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, owner=0;
  - `vp_start`=0, `vp_operation`/`vp_vec_a`/`vp_vec_b`/`vp_scalar`=0;
  - `rsp_valid`=0, `rsp_result`=0, `rsp_error`=0, `arb_busy`=0;
  - `req_ready`=0 only while `rst` is high.
- A reset during ISSUE, WAIT or RESP abandons the operation: no `rsp_valid` is produced, and the VPU is not reset by this block.
- Cycle sequence for one operation, with accept at cycle T and `vp_busy`=0:
  - `vp_start` is high in cycle T+1;
  - WAIT starts at T+2;
  - if `vp_done` is sampled at cycle D, `rsp_valid` is high at D+1 with result and error valid;
  - IDLE at D+2, so the next accept is earliest at D+2.
- Timeout path: the last WAIT cycle is T+1+TIMEOUT_CYCLES, and `rsp_valid` with error follows in the next cycle.
- `arb_busy` is high from T+1 through D+1 inclusive.

## Test plan
- **Single request.** Stimulus: req0 with op=4'h3, vec_a=64'h0001_0002_0003_0004; model VPU returns done with result_valid and result 64'hAAAA after 5 cycles. Required: `vp_start` at T+1 with the exact operands; `rsp_valid`=2'b01 at D+1; `rsp_result`=64'hAAAA; `rsp_error`=0.
- **Fairness.** Stimulus: req0 and req1 held valid continuously for 6 operations. Required grant order 0,1,0,1,0,1, and `rr_ptr` = 1,0,1,0,1,0 after each accept.
- **Timeout.** Stimulus: TIMEOUT_CYCLES=8; VPU never asserts done. Required: `rsp_valid` at T+10 with `rsp_error`=1 and `rsp_result`=0; next request is not started until `vp_busy`=0.
- **Stale and edge conditions.** Stimulus: `vp_busy`=1 at issue; `vp_done` pulsed while in IDLE; done coincident with the terminal count; done with `vp_result_valid`=0. Required: `vp_start` held off until busy drops; the IDLE done is ignored; the coincident done returns a normal result; done without result_valid gives `rsp_error`=1.
- **Reset mid-WAIT.** Stimulus: assert `rst` during WAIT, then deliver `vp_done`. Required: all outputs return to reset values the next cycle; no `rsp_valid` is produced; the next request issues correctly.
